// File: rtl/depth_test_unit_pkg.sv
// Shared types for the z-buffer depth test stage.
// Q16.16 fixed point; stored depth keeps the low DEPTH_W bits.
package depth_test_unit_pkg;

    localparam int TOTAL_WIDTH = 32;
    localparam int FRAC_W      = 16;
    localparam int DEPTH_W     = TOTAL_WIDTH / 2;
    localparam int COLOR_W     = 24;

    typedef logic [TOTAL_WIDTH-1:0] fixed_t;
    typedef logic [DEPTH_W-1:0]     depth_t;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        fixed_t             depth;
    } pixel_data_t;

    typedef enum logic [1:0] {
        CMP_GE,
        CMP_GT,
        CMP_ALWAYS,
        CMP_TEST_ONLY
    } depth_cmp_e;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_DRAIN,
        CLR_CLEAR
    } depth_clr_state_e;

    function automatic fixed_t rtof(input real r);
        return fixed_t'($rtoi(r * (2.0 ** FRAC_W)));
    endfunction

endpackage

// File: rtl/depth_test_unit_ram.sv
// Simple dual-port depth store: one synchronous read, one write.
// Read data holds while re is low; no read-during-write ordering.
module depth_ram
    import depth_test_unit_pkg::*;
#(
    parameter int DEPTH  = 19200,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output depth_t            rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  depth_t            wdata
);

    (* ram_style = "block" *) depth_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/depth_test_unit.sv
// Pipelined z-buffer test/update stage with internal clear sequencer.
// Define DEPTH_STATS_EN to add the stat_pass/stat_reject counters.
module depth_test_unit
    import depth_test_unit_pkg::*;
#(
    parameter int     BUFFER_WIDTH  = 160,
    parameter int     BUFFER_HEIGHT = 120,
    parameter int     ADDR_W        = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
    parameter real    NEAR_PLANE    = 1.0,
    parameter real    FAR_PLANE     = 10.0,
    parameter depth_t CLEAR_VALUE   = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  pixel_data_t       in_pixel,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [1:0]        cmp_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output pixel_data_t       out_pixel,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done
`ifdef DEPTH_STATS_EN
   ,output logic [31:0]       stat_pass,
    output logic [31:0]       stat_reject
`endif
);

    localparam int                N        = BUFFER_WIDTH * BUFFER_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N - 1);
    localparam fixed_t            REC_NEAR = rtof(1.0 / NEAR_PLANE);
    localparam fixed_t            REC_FAR  = rtof(1.0 / FAR_PLANE);

    depth_clr_state_e  state;
    logic              rdy_en, advance, accept, pipe_empty;
    logic              v1, v2, v3;
    pixel_data_t       pix1, pix2, pix3;
    logic [ADDR_W-1:0] addr1, addr2, addr3;
    depth_cmp_e        mode1, mode2, mode3;
    depth_t            rdata, sd2, sd3, nd3;
    logic              lw_v;
    logic [ADDR_W-1:0] lw_addr;
    depth_t            lw_data;
    logic              in_range, cmp_ok, pass3, wr3;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, clr_cnt;
    depth_t            ram_wdata;

    assign advance    = !out_valid || out_ready;
    assign in_ready   = rdy_en && advance && (state == CLR_IDLE);
    assign accept     = in_valid && in_ready;
    assign clear_busy = (state != CLR_IDLE);
    assign pipe_empty = !v1 && !v2 && !v3 && !out_valid;

    assign nd3      = pix3.depth[DEPTH_W-1:0];
    assign in_range = (pix3.depth >= REC_FAR) && (pix3.depth <= REC_NEAR);

    always_comb begin
        cmp_ok = 1'b0;
        unique case (mode3)
            CMP_GE, CMP_TEST_ONLY: cmp_ok = (nd3 >= sd3);
            CMP_GT:                cmp_ok = (nd3 > sd3);
            CMP_ALWAYS:            cmp_ok = 1'b1;
        endcase
    end

    assign pass3 = v3 && in_range && cmp_ok;
    assign wr3   = pass3 && (mode3 != CMP_TEST_ONLY) && advance;

    // Newest write wins: the S3 commit this cycle, then last cycle's commit
    // (which raced with this pixel's RAM read), then the RAM itself.
    always_comb begin
        sd2 = rdata;
        if (wr3 && (addr3 == addr2))
            sd2 = nd3;
        else if (lw_v && (lw_addr == addr2))
            sd2 = lw_data;
    end

    assign ram_we    = (state == CLR_CLEAR) || wr3;
    assign ram_waddr = (state == CLR_CLEAR) ? clr_cnt : addr3;
    assign ram_wdata = (state == CLR_CLEAR) ? CLEAR_VALUE : nd3;

    depth_ram #(
        .DEPTH  (N),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .re    (advance),
        .raddr (addr1),
        .rdata (rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            pix1      <= '0;
            pix2      <= '0;
            pix3      <= '0;
            addr1     <= '0;
            addr2     <= '0;
            addr3     <= '0;
            mode1     <= CMP_GE;
            mode2     <= CMP_GE;
            mode3     <= CMP_GE;
            sd3       <= '0;
            lw_v      <= 1'b0;
            lw_addr   <= '0;
            lw_data   <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_addr  <= '0;
        end else if (advance) begin
            v1 <= accept;
            if (accept) begin
                pix1  <= in_pixel;
                addr1 <= in_addr;
                mode1 <= depth_cmp_e'(cmp_mode);
            end
            v2        <= v1;
            pix2      <= pix1;
            addr2     <= addr1;
            mode2     <= mode1;
            v3        <= v2;
            pix3      <= pix2;
            addr3     <= addr2;
            mode3     <= mode2;
            sd3       <= sd2;
            lw_v      <= wr3;
            lw_addr   <= addr3;
            lw_data   <= nd3;
            out_valid <= pass3;
            if (pass3) begin
                out_pixel <= pix3;
                out_addr  <= addr3;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= CLR_IDLE;
            clr_cnt    <= '0;
            clear_done <= 1'b0;
            rdy_en     <= 1'b0;
        end else begin
            rdy_en     <= 1'b1;
            clear_done <= 1'b0;
            unique case (state)
                CLR_IDLE:
                    if (clear_start)
                        state <= CLR_DRAIN;
                CLR_DRAIN:
                    if (pipe_empty) begin
                        state   <= CLR_CLEAR;
                        clr_cnt <= '0;
                    end
                CLR_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST) begin
                        state      <= CLR_IDLE;
                        clear_done <= 1'b1;
                    end
                end
                default: state <= CLR_IDLE;
            endcase
        end
    end

`ifdef DEPTH_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_pass   <= '0;
            stat_reject <= '0;
        end else if ((state == CLR_IDLE) && clear_start) begin
            stat_pass   <= '0;
            stat_reject <= '0;
        end else if (advance && v3) begin
            if (pass3) begin
                if (stat_pass != '1)
                    stat_pass <= stat_pass + 1'b1;
            end else if (stat_reject != '1) begin
                stat_reject <= stat_reject + 1'b1;
            end
        end
    end
`endif

endmodule
